// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
//   state_e      : loader FSM states
//   ByteWidth    : width of one stream byte
//   BytesPerWord : bytes assembled into one memory word
//   CsumWidth    : width of the running frame checksum
package prog_loader_pkg;

    typedef enum logic [2:0] {
        StLenHi,
        StLenLo,
        StData,
        StCheck,
        StRun,
        StError
    } state_e;

    localparam int unsigned ByteWidth    = 8;
    localparam int unsigned BytesPerWord = 4;
    localparam int unsigned WordWidth    = ByteWidth * BytesPerWord;
    localparam int unsigned IdxWidth     = 2;
    localparam int unsigned CsumWidth    = 8;

    // Mod-256 accumulate; wrap-around is the point of the checksum.
    function automatic logic [CsumWidth-1:0] csum_add(input logic [CsumWidth-1:0] acc,
                                                      input logic [ByteWidth-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Loader bus: byte stream in, memory write port and boot status out.
//   master : stream source / memory / CPU side
//   slave  : the loader itself
interface prog_loader_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [7:0]            In_Data;
    logic                  In_Valid;
    logic                  In_Ready;
    logic                  Mem_WE;
    logic [31:0]           Mem_Addr;
    logic [DATA_WIDTH-1:0] Mem_WData;
    logic                  Cpu_Rst_n;
    logic                  Done;
    logic                  Error;
    logic [ADDR_WIDTH:0]   Words_Loaded;

    modport master (
        output In_Data, In_Valid,
        input  In_Ready, Mem_WE, Mem_Addr, Mem_WData, Cpu_Rst_n, Done, Error, Words_Loaded
    );

    modport slave (
        input  In_Data, In_Valid,
        output In_Ready, Mem_WE, Mem_Addr, Mem_WData, Cpu_Rst_n, Done, Error, Words_Loaded
    );
endinterface

// File: rtl/prog_loader_byte_packer.sv
// Assembles little-endian bytes into 32-bit words.
//   clk, rst_n : clock, async active-low reset (discards any partial word)
//   beat       : a data byte transfers this cycle
//   data       : the byte
//   done       : combinational, high on the beat carrying byte 3 of a word
//   word       : the complete word, valid while done is high
module prog_loader_byte_packer
    import prog_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 beat,
    input  logic [ByteWidth-1:0] data,
    output logic                 done,
    output logic [WordWidth-1:0] word
);
    logic [IdxWidth-1:0]  idx_q;
    logic [WordWidth-1:0] shift_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            shift_q <= '0;
        end else if (beat) begin
            idx_q                       <= idx_q + 1'b1;
            shift_q[{idx_q, 3'b000} +: 8] <= data;
        end
    end

    assign done = beat && (idx_q == IdxWidth'(BytesPerWord - 1));

    // The top byte arrives on the same beat as done, so splice it in directly.
    always_comb begin
        word                         = shift_q;
        word[WordWidth-ByteWidth +: 8] = data;
    end
endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader. Parses a frame (LEN_HI, LEN_LO, 4*N data bytes, checksum),
// writes assembled words to sequential memory addresses and releases the CPU reset once
// the checksum is good.
//   CLK : rising-edge clock
//   RST : asynchronous active-low reset
//   bus : slave view of prog_loader_if (stream in, memory write, boot status)
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic         CLK,
    input  logic         RST,
    prog_loader_if.slave bus
);
    localparam logic [16:0] MaxWords = 17'(1) << ADDR_WIDTH;

    state_e                 state_q, state_d;
    logic [CsumWidth-1:0]   sum_q, sum_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic                   we_q, we_d;
    logic [31:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;

    logic                   in_ready;
    logic                   xfer;
    logic                   word_done;
    logic [WordWidth-1:0]   word;
    logic [15:0]            len_full;
    logic [ADDR_WIDTH:0]    count_inc;

    assign in_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                       (state_q == StData)  || (state_q == StCheck);
    assign xfer      = bus.In_Valid && in_ready;
    assign len_full  = {len_hi_q, bus.In_Data};
    assign count_inc = count_q + 1'b1;

    prog_loader_byte_packer u_packer (
        .clk   (CLK),
        .rst_n (RST),
        .beat  (xfer && (state_q == StData)),
        .data  (bus.In_Data),
        .done  (word_done),
        .word  (word)
    );

    always_comb begin
        state_d  = state_q;
        sum_d    = sum_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        count_d  = count_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        error_d  = error_q;

        if (xfer) begin
            sum_d = csum_add(sum_q, bus.In_Data);
        end

        // Address is latched from the pre-increment count so it stays valid with the strobe.
        if (word_done) begin
            we_d    = 1'b1;
            addr_d  = 32'({count_q, 2'b00});
            wdata_d = word;
            count_d = count_inc;
        end

        unique case (state_q)
            StLenHi: begin
                if (xfer) begin
                    len_hi_d = bus.In_Data;
                    state_d  = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    if (len_full == 16'd0) begin
                        state_d = StCheck;
                    end else if ({1'b0, len_full} > MaxWords) begin
                        state_d = StError;
                        error_d = 1'b1;
                    end else begin
                        state_d = StData;
                        len_d   = len_full[ADDR_WIDTH:0];
                    end
                end
            end
            StData: begin
                if (word_done && (count_inc == len_q)) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (xfer) begin
                    if (csum_add(sum_q, bus.In_Data) == '0) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            StRun, StError: ;
            default: state_d = StLenHi;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= StLenHi;
            sum_q    <= '0;
            len_hi_q <= '0;
            len_q    <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sum_q    <= sum_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            count_q  <= count_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign bus.In_Ready     = in_ready;
    assign bus.Mem_WE       = we_q;
    assign bus.Mem_Addr     = addr_q;
    assign bus.Mem_WData    = wdata_q;
    assign bus.Cpu_Rst_n    = done_q;
    assign bus.Done         = done_q;
    assign bus.Error        = error_q;
    assign bus.Words_Loaded = count_q;
endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    localparam int unsigned AW = 8;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    prog_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int n;          // value placed in LEN
        int nsend;      // data words actually streamed
        bit send_cs;    // stream a checksum byte
        int csum_delta; // added to the correct checksum
        bit gaps;       // random idle cycles between bytes
        bit exp_done;
        bit exp_error;
        int exp_words;
    } vec_t;

    wr_t        sb[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] tb_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: every write strobe must match the next expected write.
    always @(negedge CLK) begin
        if (RST && bus.Mem_WE === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", bus.Mem_Addr, e.addr);
                chk("wr_data", bus.Mem_WData, e.data);
            end
        end
    end

    function automatic logic [31:0] gen_word(input int i);
        logic [31:0] fixed [3];
        fixed[0] = 32'h0000_0045;
        fixed[1] = 32'h1234_5678;
        fixed[2] = 32'hDEAD_BEEF;
        if (i < 3) return fixed[i];
        return 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    // Inputs change #1 after a rising edge; In_Ready is stable until the next edge.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        int waited = 0;
        if (gaps) begin
            bus.In_Valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge CLK);
                #1;
            end
        end
        bus.In_Data  = b;
        bus.In_Valid = 1'b1;
        while (!ok && waited < 20) begin
            ok = (bus.In_Ready === 1'b1);
            @(posedge CLK);
            #1;
            waited++;
        end
        if (!ok) chk("xfer_timeout", 32'd0, 32'd1);
        tb_sum = tb_sum + b;
    endtask

    task automatic send_word(input int i, input bit gaps);
        logic [31:0] w;
        w = gen_word(i);
        for (int b = 0; b < 4; b++) begin
            if (b == 3) sb.push_back({32'(i * 4), w});
            send_byte(w[8*b +: 8], gaps);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.In_Ready), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.Mem_WE), 32'd0);
        chk({tag, "_mem_addr"}, bus.Mem_Addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.Mem_WData, 32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(bus.Cpu_Rst_n), 32'd0);
        chk({tag, "_done"}, 32'(bus.Done), 32'd0);
        chk({tag, "_error"}, 32'(bus.Error), 32'd0);
        chk({tag, "_words"}, 32'(bus.Words_Loaded), 32'd0);
    endtask

    task automatic do_reset();
        bus.In_Valid = 1'b0;
        bus.In_Data  = 8'h00;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        sb.delete();
        #1;
        check_reset_vals("rst");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic check_end(input string tag, input vec_t v);
        chk({tag, "_done"}, 32'(bus.Done), 32'(v.exp_done));
        chk({tag, "_cpu_rst_n"}, 32'(bus.Cpu_Rst_n), 32'(v.exp_done));
        chk({tag, "_error"}, 32'(bus.Error), 32'(v.exp_error));
        chk({tag, "_in_ready"}, 32'(bus.In_Ready), 32'd0);
        chk({tag, "_words"}, 32'(bus.Words_Loaded), 32'(v.exp_words));
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0]  c;
        logic [31:0] nv;
        string       tag;
        tag = $sformatf("v%0d", idx);
        nv  = 32'(v.n);
        tb_sum = 8'h00;
        send_byte(nv[15:8], v.gaps);
        send_byte(nv[7:0], v.gaps);
        for (int i = 0; i < v.nsend; i++) send_word(i, v.gaps);
        if (v.send_cs) begin
            c = 8'h00 - tb_sum;
            c = c + 8'(v.csum_delta);
            send_byte(c, v.gaps);
        end
        bus.In_Valid = 1'b0;
        check_end(tag, v);
        // Bytes offered in a terminal state must be ignored.
        bus.In_Data  = 8'h5A;
        bus.In_Valid = 1'b1;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        bus.In_Valid = 1'b0;
        check_end({tag, "_idle"}, v);
    endtask

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            n    nsend cs delta gaps done err words
        vecs[0] = '{3,   3,   1, 0, 0, 1, 0, 3};
        vecs[1] = '{3,   3,   1, 1, 0, 0, 1, 3};
        vecs[2] = '{0,   0,   1, 0, 0, 1, 0, 0};
        vecs[3] = '{257, 0,   0, 0, 0, 0, 1, 0};
        vecs[4] = '{256, 256, 1, 0, 0, 1, 0, 256};
        vecs[5] = '{2,   2,   1, 0, 1, 1, 0, 2};
        vecs[6] = '{1,   1,   1, 0, 1, 1, 0, 1};

        bus.In_Valid = 1'b0;
        bus.In_Data  = 8'h00;
        #1;
        check_reset_vals("por");

        for (int i = 0; i < 7; i++) begin
            do_reset();
            run_vec(i, vecs[i]);
        end

        // Async reset in the middle of word 1 of a 2-word frame.
        do_reset();
        tb_sum = 8'h00;
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(0, 1'b0);
        send_byte(8'h78, 1'b0);
        send_byte(8'h56, 1'b0);
        bus.In_Valid = 1'b0;
        chk("mid_words", 32'(bus.Words_Loaded), 32'd1);
        chk("mid_wdata", bus.Mem_WData, 32'h0000_0045);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);
        #2;
        RST = 1'b0;
        #1;
        check_reset_vals("async");
        @(posedge CLK);
        #3;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        begin
            vec_t v;
            v = '{1, 1, 1, 0, 0, 1, 0, 1};
            run_vec(99, v);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Boot-time program loader for the multicycle CPU. It accepts a framed byte stream on a valid/ready interface and assembles the bytes into 32-bit little-endian words. It writes the words sequentially into the CPU's unified memory through a single-cycle write port, checks a trailing checksum, and holds the CPU in reset until the image has loaded cleanly. The memory is written here and read by the CPU, so this block sits between the host/bench stream source and the memory write port, alongside the top level.

## Interface
- ADDR_WIDTH, 8: word-address width; memory depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32: memory word width; fixed at 4 bytes.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-low reset
- In_Data  in  8  stream byte
- In_Valid  in  1  In_Data valid
- In_Ready  out  1  loader can accept a byte
- Mem_WE  out  1  memory write strobe, one cycle per word
- Mem_Addr  out  32  byte address of the write, word-aligned: 4*k
- Mem_WData  out  32  assembled word
- Cpu_Rst_n  out  1  active-low reset to the CPU; 0 until the load succeeds
- Done  out  1  load completed with a good checksum
- Error  out  1  load aborted
- Words_Loaded  out  ADDR_WIDTH+1  number of words written so far

## Operation
- Frame format, in byte order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - 4*N data bytes, each word sent least-significant byte first.
  - One checksum byte C, chosen so that the mod-256 sum of every frame byte, C included, is 0x00.
- A byte transfers on a rising CLK when In_Valid and In_Ready are both 1. In_Data is ignored otherwise.
- States and transitions:
  - S_LEN_HI → S_LEN_LO on a transfer.
  - S_LEN_LO → S_DATA on a transfer when 0 < N ≤ 2^ADDR_WIDTH.
  - S_LEN_LO → S_CHECK on a transfer when N == 0.
  - S_LEN_LO → S_ERROR on a transfer when N > 2^ADDR_WIDTH.
  - S_DATA → S_CHECK when the 4th byte of word N−1 transfers.
  - S_CHECK → S_RUN on a transfer when the running sum plus C == 0x00.
  - S_CHECK → S_ERROR on a transfer when the sum is nonzero.
  - S_RUN and S_ERROR are terminal; only RST leaves them.
- In_Ready = 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CHECK; 0 in S_RUN and S_ERROR.
- Running sum: 8-bit accumulator, wraps mod 256, cleared by reset, adds every transferred byte.
- Word assembly: a 2-bit byte index and a 32-bit shift register. Byte i of a word lands in bits [8i+7:8i].
- Word counter k: ADDR_WIDTH+1 bits, increments on each write. Words_Loaded = k. Mem_Addr = {k, 2'b00}, zero-extended to 32 bits.
- Bytes offered while In_Ready = 0 (the RUN/ERROR states) are not consumed and have no effect.

## Timing
- Reset values:
  - In_Ready=1, Mem_WE=0, Mem_Addr=0, Mem_WData=0.
  - Cpu_Rst_n=0, Done=0, Error=0, Words_Loaded=0.
  - State S_LEN_HI, sum 0, byte index 0.
- Mem_WE is registered. It is high for exactly the one cycle after the edge that transfers the 4th byte of a word, with Mem_Addr/Mem_WData stable for that cycle. Words_Loaded updates on that same edge.
- Back-to-back bytes at one per cycle are fully supported. Writes are therefore at least 4 cycles apart, and no stall is needed.
- The last data write always completes before the checksum byte can be accepted.
- Cpu_Rst_n and Done go to 1 on the edge that accepts a good checksum, and stay at 1 until RST.
- Error goes to 1 on the edge that accepts a bad checksum or an oversize LEN_LO. Cpu_Rst_n stays 0.
- Done and Error are never high together.
- RST asserted at any point clears all state asynchronously, including mid-word. Cpu_Rst_n drops to 0 immediately without waiting for CLK, and a partial word is discarded. After RST deasserts, the next accepted byte is treated as LEN_HI.
- The boundary N = 2^ADDR_WIDTH is accepted, and Words_Loaded reaches 2^ADDR_WIDTH. N = 2^ADDR_WIDTH + 1 is an error.

## Structure
- Shared package: state enum, frame-byte constants, and the checksum width (8).
- One natural sub-module: byte_packer, which holds the byte index and shift register and emits the word-complete pulse and the word.
- Everything else stays in prog_loader: FSM, counter, checksum and outputs.

## Test plan
- Load 3 words, all bytes with In_Valid held high:
  - Stream: 00 03, then 0x00000045, 0x12345678, 0xDEADBEEF as little-endian bytes, then the correct C.
  - Expect three Mem_WE pulses, at addresses 0x0, 0x4, 0x8, with those data values.
  - Expect Words_Loaded=3, Done=1, Cpu_Rst_n=1 and Error=0.
- Repeat the 3-word load with a checksum off by one: all three writes occur, then Error=1, Done=0, Cpu_Rst_n=0 and In_Ready=0.
- Send 00 00 followed by C=0x00: no Mem_WE pulse, then Done=1 and Cpu_Rst_n=1.
- Oversize length with ADDR_WIDTH=8:
  - Send 01 01 (N=257): Error=1 on the LEN_LO edge, no writes.
  - Send 01 00 (N=256) with its data and checksum: 256 writes, last address 0x3FC, Done=1.
- Throttled input: drive In_Valid with random gaps during a 2-word load. Data and addresses must match the no-gap case, and no byte may be duplicated or dropped.
- Assert RST after byte 2 of the second word: all outputs return to their reset values immediately. A subsequent full 1-word frame then loads to address 0x0 and reaches Done=1.
